multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle CPU control unit. Sequences IF/ID/EXE/MEM/WB and drives the PC
//  register's PCWre and PCSrc, plus IR, ALU, register-file and data-memory
//  controls. Sits between the instruction register (opcode) and the ALU flags.
//  Issues exactly one PC update per retired instruction.
// PARAMETERS
//  OPW      6  opcode width
//  STATE_W  3  state register width
// PORTS
//  CLK        in   1    clock, rising edge
//  RST        in   1    synchronous reset, active-low
//  opcode     in   OPW  IR[31:26]; stable while IRWre=0
//  zero       in   1    ALU result == 0
//  sign       in   1    ALU result[31]
//  PCWre      out  1    PC update enable
//  PCSrc      out  2    00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target
//  InsMemRW   out  1    1 = instruction memory read
//  IRWre      out  1    IR load enable
//  ExtSel     out  1    0 zero-extend imm16, 1 sign-extend imm16
//  ALUSrcA    out  1    0 rs, 1 shamt
//  ALUSrcB    out  1    0 rt, 1 extended imm
//  ALUOp      out  3    000 add, 001 sub, 010 sll, 011 or, 100 and, 110 slt (signed), 111 xor
//  RegWre     out  1    register-file write enable
//  RegDst     out  2    00 $31, 01 rt, 10 rd
//  WrRegDSrc  out  1    0 PC+4, 1 DB data
//  DBDataSrc  out  1    0 ALU result, 1 data-memory read
//  mRD        out  1    data-memory read
//  mWR        out  1    data-memory write
//  state      out  STATE_W  current state, debug
// BEHAVIOUR
//  - States: IF=000 ID=001 EXE_LS=010 MEM=011 WB_LD=100 EXE_BR=101 EXE_AL=110 WB_AL=111.
//  - RST==0 at a CLK edge: state<=IF. Outputs are combinational from state, opcode, zero, sign.
//  - Output values in IF, including during reset: InsMemRW=1, IRWre=1, all others 0.
//  - Opcodes: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010,
//    xori 010011, sll 011000, slti 100110, slt 100111, sw 110000, lw 110001, beq 110100,
//    bne 110101, bltz 110110, j 111000, jr 111001, jal 111010, halt 111111.
//  - Transitions:
//    - IF->ID.
//    - ID: j/jr/jal/unknown ->IF; halt ->ID (self-loop, PCWre=0, never leaves until RST).
//    - ID: beq/bne/bltz ->EXE_BR; lw/sw ->EXE_LS; else ->EXE_AL.
//    - EXE_AL->WB_AL->IF. EXE_BR->IF. EXE_LS->MEM.
//    - MEM: sw ->IF, lw ->WB_LD. WB_LD->IF.
//  - PCWre=1 only in the cycle leaving to IF (ID for j/jr/jal/unknown, EXE_BR, WB_AL,
//    MEM for sw, WB_LD). It is 1 for exactly 1 cycle per instruction and never in IF.
//  - PCSrc, valid when PCWre=1:
//    - j/jal 11; jr 10.
//    - 01 if beq&zero, bne&!zero, or bltz&sign; otherwise 00.
//    - Unknown opcode executes as nop: PCSrc=00.
//  - jal: in ID, RegWre=1, RegDst=00, WrRegDSrc=0.
//  - ALU controls are held constant from EXE through the instruction's final state:
//    - ExtSel=0 for andi/ori/xori, else 1.
//    - ALUSrcB=1 for addiu/andi/ori/xori/slti/lw/sw.
//    - ALUSrcA=1 for sll only.
//    - Branches use ALUOp=001 and ALUSrcB=0; bltz relies on rt=$0.
//  - Writes: WB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0; RegDst=10 for R-type, 01 for imm-type.
//  - MEM: mWR=1 for sw, mRD=1 for lw.
//  - WB_LD: mRD=1, DBDataSrc=1, RegWre=1, RegDst=01, WrRegDSrc=1.
//  - RegWre, mWR and PCWre are 0 in all other states. No write enable is ever asserted in IF.
//  - Reset mid-instruction: the next cycle is IF. No partial write completes after the reset edge.
// CONFIGURATION
//  MC_CTRL_PERF_CNT_EN defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
//  - Both reset to 0.
//  - cycle_cnt increments every cycle with RST=1.
//  - instr_cnt increments on every PCWre=1 cycle.
//  - Both wrap 0xFFFFFFFF->0.
//  - Halt cycles count in cycle_cnt only.
//  Undefined: the ports and logic are absent; all other behaviour is identical.
// TESTING
//  - add (000000): states 000,001,110,111,000. PCWre=1 only in 111, PCSrc=00;
//    RegWre=1, RegDst=10 in 111.
//  - lw (110001): 000,001,010,011,100,000. mRD=1 in 011/100. RegWre=1, RegDst=01,
//    DBDataSrc=1 in 100. 5 cycles.
//  - beq with zero=1 and with zero=0: 3 cycles each, PCSrc=01 then 00 in 101;
//    bltz with sign=1 gives PCSrc=01.
//  - jal (111010): 2 cycles; in ID PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
//  - halt (111111): state stays 001 for 100 cycles with PCWre=0.
//    RST=0 for one edge: state=000, IRWre=1.
//  - RST=0 asserted in MEM of sw: mWR drops after the edge, state=000.
//    With MC_CTRL_PERF_CNT_EN, 10 sequential add: instr_cnt=10, cycle_cnt=40.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB); outputs are combinational from state/opcode/flags.
// Optional MC_CTRL_PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module multicycle_ctrl_fsm #(
    parameter int OPW     = 6,
    parameter int STATE_W = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [OPW-1:0]     opcode,
    input  logic               zero,
    input  logic               sign,
    output logic               PCWre,
    output logic [1:0]         PCSrc,
    output logic               InsMemRW,
    output logic               IRWre,
    output logic               ExtSel,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic               RegWre,
    output logic [1:0]         RegDst,
    output logic               WrRegDSrc,
    output logic               DBDataSrc,
    output logic               mRD,
    output logic               mWR,
`ifdef MC_CTRL_PERF_CNT_EN
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt,
`endif
    output logic [STATE_W-1:0] state
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] op;
    logic       alu_en;

    assign op    = opcode[5:0];
    assign state = STATE_W'(state_q);

    // Opcode decode
    logic is_add, is_sub, is_addiu, is_and, is_andi, is_ori, is_xori, is_sll;
    logic is_slti, is_slt, is_sw, is_lw, is_beq, is_bne, is_bltz, is_j, is_jr, is_jal, is_halt;
    logic is_rtype, is_imm, is_branch, is_known, br_taken;

    assign is_add   = (op == 6'b000000);
    assign is_sub   = (op == 6'b000001);
    assign is_addiu = (op == 6'b000010);
    assign is_and   = (op == 6'b010000);
    assign is_andi  = (op == 6'b010001);
    assign is_ori   = (op == 6'b010010);
    assign is_xori  = (op == 6'b010011);
    assign is_sll   = (op == 6'b011000);
    assign is_slti  = (op == 6'b100110);
    assign is_slt   = (op == 6'b100111);
    assign is_sw    = (op == 6'b110000);
    assign is_lw    = (op == 6'b110001);
    assign is_beq   = (op == 6'b110100);
    assign is_bne   = (op == 6'b110101);
    assign is_bltz  = (op == 6'b110110);
    assign is_j     = (op == 6'b111000);
    assign is_jr    = (op == 6'b111001);
    assign is_jal   = (op == 6'b111010);
    assign is_halt  = (op == 6'b111111);

    assign is_rtype  = is_add | is_sub | is_and | is_sll | is_slt;
    assign is_imm    = is_addiu | is_andi | is_ori | is_xori | is_slti;
    assign is_branch = is_beq | is_bne | is_bltz;
    assign is_known  = is_rtype | is_imm | is_branch | is_sw | is_lw | is_halt
                     | is_j | is_jr | is_jal;
    assign br_taken  = (is_beq & zero) | (is_bne & ~zero) | (is_bltz & sign);

    // ALU controls are a pure function of the opcode, gated on in EXE..WB
    assign ExtSel  = alu_en & ~(is_andi | is_ori | is_xori);
    assign ALUSrcA = alu_en & is_sll;
    assign ALUSrcB = alu_en & (is_imm | is_lw | is_sw);

    always_comb begin
        ALUOp = 3'b000;
        if (alu_en) begin
            if (is_sub | is_branch)      ALUOp = 3'b001;
            else if (is_sll)             ALUOp = 3'b010;
            else if (is_ori)             ALUOp = 3'b011;
            else if (is_and | is_andi)   ALUOp = 3'b100;
            else if (is_slt | is_slti)   ALUOp = 3'b110;
            else if (is_xori)            ALUOp = 3'b111;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= S_IF;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        alu_en    = 1'b0;
        PCWre     = 1'b0;
        PCSrc     = 2'b00;
        InsMemRW  = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        // Reset forces fetch-state outputs so no write enable fires at the reset edge
        if (!RST) begin
            state_d  = S_IF;
            InsMemRW = 1'b1;
            IRWre    = 1'b1;
        end else begin
            unique case (state_q)
                S_IF: begin
                    InsMemRW = 1'b1;
                    IRWre    = 1'b1;
                    state_d  = S_ID;
                end
                S_ID: begin
                    if (is_halt) begin
                        state_d = S_ID;
                    end else if (is_j | is_jr | is_jal | !is_known) begin
                        PCWre   = 1'b1;
                        PCSrc   = (is_j | is_jal) ? 2'b11 : (is_jr ? 2'b10 : 2'b00);
                        RegWre  = is_jal;
                        state_d = S_IF;
                    end else if (is_branch) begin
                        state_d = S_EXE_BR;
                    end else if (is_lw | is_sw) begin
                        state_d = S_EXE_LS;
                    end else begin
                        state_d = S_EXE_AL;
                    end
                end
                S_EXE_LS: begin
                    alu_en  = 1'b1;
                    state_d = S_MEM;
                end
                S_MEM: begin
                    alu_en = 1'b1;
                    if (is_sw) begin
                        mWR     = 1'b1;
                        PCWre   = 1'b1;
                        state_d = S_IF;
                    end else begin
                        mRD     = 1'b1;
                        state_d = S_WB_LD;
                    end
                end
                S_WB_LD: begin
                    alu_en    = 1'b1;
                    mRD       = 1'b1;
                    DBDataSrc = 1'b1;
                    RegWre    = 1'b1;
                    RegDst    = 2'b01;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                    state_d   = S_IF;
                end
                S_EXE_BR: begin
                    alu_en  = 1'b1;
                    PCWre   = 1'b1;
                    PCSrc   = br_taken ? 2'b01 : 2'b00;
                    state_d = S_IF;
                end
                S_EXE_AL: begin
                    alu_en  = 1'b1;
                    state_d = S_WB_AL;
                end
                S_WB_AL: begin
                    alu_en    = 1'b1;
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    RegDst    = is_rtype ? 2'b10 : 2'b01;
                    PCWre     = 1'b1;
                    state_d   = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (PCWre) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: walks instruction classes, halt, and mid-instruction reset.
module tb_multicycle_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] opcode;
    logic       zero, sign;
    logic       PCWre, InsMemRW, IRWre, ExtSel, ALUSrcA, ALUSrcB, RegWre;
    logic       WrRegDSrc, DBDataSrc, mRD, mWR;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    multicycle_ctrl_fsm #(.OPW(6), .STATE_W(3)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .PCSrc(PCSrc), .InsMemRW(InsMemRW), .IRWre(IRWre),
        .ExtSel(ExtSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
        .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR),
`ifdef MC_CTRL_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
        .state(state)
    );

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int bad;
        RST = 1'b0; opcode = 6'b000000; zero = 1'b0; sign = 1'b0;

        // Reset state
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_irwre", 32'(IRWre), 1);
        chk("rst_insmem", 32'(InsMemRW), 1);
        chk("rst_pcwre", 32'(PCWre), 0);
        chk("rst_regwre", 32'(RegWre), 0);
        RST = 1'b1;

        // add: IF ID EXE_AL WB_AL IF
        tick(); chk("add_id", 32'(state), 1);      chk("add_id_pcwre", 32'(PCWre), 0);
        tick(); chk("add_exe", 32'(state), 6);     chk("add_exe_pcwre", 32'(PCWre), 0);
        chk("add_exe_aluop", 32'(ALUOp), 0);       chk("add_exe_srcb", 32'(ALUSrcB), 0);
        chk("add_exe_regwre", 32'(RegWre), 0);
        tick(); chk("add_wb", 32'(state), 7);      chk("add_wb_pcwre", 32'(PCWre), 1);
        chk("add_wb_pcsrc", 32'(PCSrc), 0);        chk("add_wb_regwre", 32'(RegWre), 1);
        chk("add_wb_regdst", 32'(RegDst), 2);      chk("add_wb_wrsrc", 32'(WrRegDSrc), 1);
        tick(); chk("add_if", 32'(state), 0);      chk("add_if_pcwre", 32'(PCWre), 0);

        // lw: IF ID EXE_LS MEM WB_LD IF
        opcode = 6'b110001;
        tick(); chk("lw_id", 32'(state), 1);
        tick(); chk("lw_exe", 32'(state), 2);      chk("lw_exe_srcb", 32'(ALUSrcB), 1);
        chk("lw_exe_ext", 32'(ExtSel), 1);
        tick(); chk("lw_mem", 32'(state), 3);      chk("lw_mem_mrd", 32'(mRD), 1);
        chk("lw_mem_pcwre", 32'(PCWre), 0);        chk("lw_mem_mwr", 32'(mWR), 0);
        tick(); chk("lw_wb", 32'(state), 4);       chk("lw_wb_mrd", 32'(mRD), 1);
        chk("lw_wb_regwre", 32'(RegWre), 1);       chk("lw_wb_regdst", 32'(RegDst), 1);
        chk("lw_wb_dbsrc", 32'(DBDataSrc), 1);     chk("lw_wb_pcwre", 32'(PCWre), 1);
        tick(); chk("lw_if", 32'(state), 0);

        // beq taken / not taken, bltz taken
        opcode = 6'b110100; zero = 1'b1;
        tick(); chk("beq1_id", 32'(state), 1);
        tick(); chk("beq1_br", 32'(state), 5);     chk("beq1_pcsrc", 32'(PCSrc), 1);
        chk("beq1_pcwre", 32'(PCWre), 1);          chk("beq1_aluop", 32'(ALUOp), 1);
        chk("beq1_srcb", 32'(ALUSrcB), 0);
        tick(); chk("beq1_if", 32'(state), 0);
        zero = 1'b0;
        tick(); tick();
        chk("beq0_br", 32'(state), 5);             chk("beq0_pcsrc", 32'(PCSrc), 0);
        tick(); chk("beq0_if", 32'(state), 0);
        opcode = 6'b110110; sign = 1'b1;
        tick(); tick();
        chk("bltz_pcsrc", 32'(PCSrc), 1);          chk("bltz_pcwre", 32'(PCWre), 1);
        tick(); sign = 1'b0;

        // jal: 2 cycles, links $31 in ID
        opcode = 6'b111010;
        tick(); chk("jal_id", 32'(state), 1);      chk("jal_pcwre", 32'(PCWre), 1);
        chk("jal_pcsrc", 32'(PCSrc), 3);           chk("jal_regwre", 32'(RegWre), 1);
        chk("jal_regdst", 32'(RegDst), 0);         chk("jal_wrsrc", 32'(WrRegDSrc), 0);
        tick(); chk("jal_if", 32'(state), 0);

        // ori: zero-extend, imm-type destination
        opcode = 6'b010010;
        tick(); tick();
        chk("ori_ext", 32'(ExtSel), 0);            chk("ori_aluop", 32'(ALUOp), 3);
        tick(); chk("ori_regdst", 32'(RegDst), 1);
        tick();

        // sw with reset asserted in MEM
        opcode = 6'b110000;
        tick(); tick(); tick();
        chk("sw_mem", 32'(state), 3);              chk("sw_mem_mwr", 32'(mWR), 1);
        RST = 1'b0;
        tick(); chk("sw_rst_state", 32'(state), 0); chk("sw_rst_mwr", 32'(mWR), 0);
        chk("sw_rst_irwre", 32'(IRWre), 1);
        RST = 1'b1;

        // halt: stuck in ID with no PC update
        opcode = 6'b111111;
        tick();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (state !== 3'd1 || PCWre !== 1'b0) bad++;
            tick();
        end
        chk("halt_hold_bad", 32'(bad), 0);
        RST = 1'b0;
        tick(); chk("halt_rst_state", 32'(state), 0); chk("halt_rst_irwre", 32'(IRWre), 1);
        RST = 1'b1;

`ifdef MC_CTRL_PERF_CNT_EN
        RST = 1'b0;
        tick(); chk("perf_rst_cyc", cycle_cnt, 0); chk("perf_rst_ins", instr_cnt, 0);
        RST = 1'b1; opcode = 6'b000000;
        for (int i = 0; i < 40; i++) tick();
        chk("perf_cyc", cycle_cnt, 40);            chk("perf_ins", instr_cnt, 10);
        chk("perf_state", 32'(state), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
